ad_ip_jesd204_tpl_dac_stream_ctrl: RTL and testbench

Next-generation DMA-to-framer stream controller for the JESD204 TPL DAC, running in the link clock domain.
- Buffers DMA samples in a parametrised elastic FIFO and gates transmission start on prefill level and, optionally, an external sync edge.
- Masks disabled channels and tracks underflow.
- Sits between the DMA interface and the TPL framer/datapath; replaces the fixed always-valid DMA request scheme.

---
 rtl/ad_ip_jesd204_tpl_dac_pkg.sv | 23 ++
 rtl/ad_ip_jesd204_tpl_dac_fifo.sv | 66 ++++++
 rtl/ad_ip_jesd204_tpl_dac_stream_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_stream_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared state encoding and constants for the TPL DAC stream controller.
// Optional underflow event counter is enabled by TPL_DAC_STREAM_UNF_CNT_EN.
package ad_ip_jesd204_tpl_dac_pkg;

  localparam int STATE_W   = 2;
  localparam int UNF_CNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_PREFILL   = 2'd1,
    ST_WAIT_SYNC = 2'd2,
    ST_RUN       = 2'd3
  } tpl_state_e;

  localparam logic [UNF_CNT_W-1:0] UNF_CNT_MAX = '1;

  function automatic logic [UNF_CNT_W-1:0] unf_sat_inc(
    input logic [UNF_CNT_W-1:0] v
  );
    return (v == UNF_CNT_MAX) ? v : v + UNF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Synchronous elastic FIFO with wrap-bit pointers, flush and level.
// Build option TPL_DAC_STREAM_UNF_CNT_EN does not affect this file.
module ad_ip_jesd204_tpl_dac_fifo #(
  parameter int WIDTH      = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q;
  logic [ADDR_WIDTH:0] wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q;
  logic [ADDR_WIDTH:0] rd_ptr_d;
  logic                do_push;
  logic                do_pop;

  // Same index with opposite wrap bits means the write side lapped the read side
  assign full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_stream_ctrl.sv
// DMA-to-framer stream controller: prefill/sync gated start, masking, underflow.
// Define TPL_DAC_STREAM_UNF_CNT_EN to build the saturating underflow counter.
module ad_ip_jesd204_tpl_dac_stream_ctrl
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_PATH_WIDTH = 2,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int START_THRESHOLD = 8,
  localparam int DW = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ctrl_arm,
  input  logic                       ctrl_stop,
  input  logic                       ctrl_ext_sync_en,
  input  logic                       ext_sync,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic [DW-1:0]              s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       link_ready,
  output logic                       link_valid,
  output logic [DW-1:0]              link_data,
  output logic [STATE_W-1:0]         status_state,
  output logic [FIFO_ADDR_WIDTH:0]   status_level,
  output logic                       status_unf,
  input  logic                       status_clr,
  output logic [UNF_CNT_W-1:0]       status_unf_count
);

  localparam int CH_W = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
  localparam logic [FIFO_ADDR_WIDTH:0] THRESH =
    (FIFO_ADDR_WIDTH + 1)'(START_THRESHOLD);

  tpl_state_e               state_q;
  tpl_state_e               state_d;
  logic [DW-1:0]            link_data_q;
  logic [DW-1:0]            link_data_d;
  logic                     link_valid_q;
  logic                     sync_q;
  logic                     unf_q;
  logic                     unf_d;

  logic                     fifo_flush;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [DW-1:0]            fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FIFO_ADDR_WIDTH:0] fifo_level;
  logic [DW-1:0]            masked;
  logic                     unf_evt;
  logic                     sync_edge;

  assign fifo_flush = ctrl_stop || (state_q == ST_IDLE);
  assign s_ready    = (state_q != ST_IDLE) && !fifo_full;
  assign fifo_push  = s_valid && s_ready;
  assign sync_edge  = ext_sync && !sync_q;

  ad_ip_jesd204_tpl_dac_fifo #(
    .WIDTH      (DW),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (s_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    masked = fifo_rdata;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!enable[c]) masked[c*CH_W +: CH_W] = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    link_data_d = link_data_q;
    fifo_pop    = 1'b0;
    unf_evt     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        link_data_d = '0;
        if (ctrl_arm) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (fifo_level >= THRESH)
          state_d = ctrl_ext_sync_en ? ST_WAIT_SYNC : ST_RUN;
      end
      ST_WAIT_SYNC: begin
        if (sync_edge) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (link_ready) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            link_data_d = masked;
          end else begin
            link_data_d = '0;
            unf_evt     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Stop overrides everything, including a same-cycle arm
    if (ctrl_stop) begin
      state_d     = ST_IDLE;
      link_data_d = '0;
      fifo_pop    = 1'b0;
      unf_evt     = 1'b0;
    end
  end

  always_comb begin
    unf_d = unf_q;
    if (unf_evt)         unf_d = 1'b1;
    else if (status_clr) unf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      sync_q       <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_data_q  <= link_data_d;
      link_valid_q <= 1'b1;
      sync_q       <= ext_sync;
      unf_q        <= unf_d;
    end
  end

`ifdef TPL_DAC_STREAM_UNF_CNT_EN
  logic [UNF_CNT_W-1:0] unf_cnt_q;
  logic [UNF_CNT_W-1:0] unf_cnt_d;
  logic                 idle_entry;

  assign idle_entry = (state_d == ST_IDLE) && (state_q != ST_IDLE);

  always_comb begin
    unf_cnt_d = unf_cnt_q;
    if (status_clr || idle_entry)
      unf_cnt_d = unf_evt ? UNF_CNT_W'(1) : '0;
    else if (unf_evt)
      unf_cnt_d = unf_sat_inc(unf_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) unf_cnt_q <= '0;
    else       unf_cnt_q <= unf_cnt_d;
  end

  assign status_unf_count = unf_cnt_q;
`else
  assign status_unf_count = '0;
`endif

  assign link_data    = link_data_q;
  assign link_valid   = link_valid_q;
  assign status_state = state_q;
  assign status_level = fifo_level;
  assign status_unf   = unf_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_stream_ctrl.sv
// Self-checking bench for the TPL DAC stream controller.
// Expected values come from a queue-based reference model of the stream rules.
module tb_ad_ip_jesd204_tpl_dac_stream_ctrl;

  localparam int NCH   = 4;
  localparam int DPW   = 2;
  localparam int BPS   = 16;
  localparam int AW    = 4;
  localparam int THR   = 8;
  localparam int CHW   = DPW * BPS;
  localparam int DW    = NCH * CHW;
  localparam int DEPTH = 1 << AW;
`ifdef TPL_DAC_STREAM_UNF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            ctrl_arm, ctrl_stop, ctrl_ext_sync_en, ext_sync;
  logic [NCH-1:0]  enable;
  logic [DW-1:0]   s_data;
  logic            s_valid, s_ready;
  logic            link_ready, link_valid;
  logic [DW-1:0]   link_data;
  logic [1:0]      status_state;
  logic [AW:0]     status_level;
  logic            status_unf, status_clr;
  logic [15:0]     status_unf_count;

  int errors = 0;
  int checks = 0;

  // reference model
  int            m_state;
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data;
  bit            m_valid, m_unf, m_sync_prev;
  int            m_cnt;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_stream_ctrl #(
    .NUM_CHANNELS    (NCH),
    .DATA_PATH_WIDTH (DPW),
    .BITS_PER_SAMPLE (BPS),
    .FIFO_ADDR_WIDTH (AW),
    .START_THRESHOLD (THR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl_arm         (ctrl_arm),
    .ctrl_stop        (ctrl_stop),
    .ctrl_ext_sync_en (ctrl_ext_sync_en),
    .ext_sync         (ext_sync),
    .enable           (enable),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .link_ready       (link_ready),
    .link_valid       (link_valid),
    .link_data        (link_data),
    .status_state     (status_state),
    .status_level     (status_level),
    .status_unf       (status_unf),
    .status_clr       (status_clr),
    .status_unf_count (status_unf_count)
  );

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] ref_mask(input logic [DW-1:0] b,
                                             input logic [NCH-1:0] en);
    logic [DW-1:0] r;
    r = b;
    for (int i = 0; i < DW; i++) if (!en[i / CHW]) r[i] = 1'b0;
    return r;
  endfunction

  function automatic int exp_cnt();
    return CNT_EN ? m_cnt : 0;
  endfunction

  function automatic bit exp_ready();
    return (m_state != 0) && (m_q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_data = '0;
    m_valid = 0; m_unf = 0; m_sync_prev = 0; m_cnt = 0;
  endtask

  task automatic clear_pulses();
    ctrl_arm = 0; ctrl_stop = 0; status_clr = 0;
  endtask

  // Advance model by one clock using the inputs currently driven, then clock the DUT.
  task automatic step();
    int ns;
    bit ev, pop, push, flush, entering;
    logic [DW-1:0] nd;
    ns = m_state; ev = 0; pop = 0; nd = m_data;
    push  = s_valid && exp_ready();
    flush = ctrl_stop || (m_state == 0);
    case (m_state)
      0: if (ctrl_arm) ns = 1;
      1: if (m_q.size() >= THR) ns = ctrl_ext_sync_en ? 2 : 3;
      2: if (ext_sync && !m_sync_prev) ns = 3;
      3: if (link_ready) begin
           if (m_q.size() > 0) begin pop = 1; nd = ref_mask(m_q[0], enable); end
           else begin nd = '0; ev = 1; end
         end
      default: ;
    endcase
    if (ctrl_stop) begin ns = 0; pop = 0; ev = 0; end
    if (flush) nd = '0;
    entering = (ns == 0) && (m_state != 0);
    if (status_clr || entering) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < 65535) m_cnt = m_cnt + 1;
    if (ev) m_unf = 1; else if (status_clr) m_unf = 0;
    if (flush) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(s_data);
    end
    m_sync_prev = ext_sync; m_state = ns; m_data = nd; m_valid = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; clear_pulses();
    ctrl_ext_sync_en = 0; ext_sync = 0; enable = '1;
    s_data = '0; s_valid = 0; link_ready = 0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (status_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", status_state); end
    checks++; if (link_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", link_valid); end
    checks++; if (link_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", link_data); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", s_ready); end
    checks++; if (status_level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", status_level); end
    checks++; if (status_unf !== 1'b0 || status_unf_count !== 16'd0) begin errors++; $display("FAIL reset_unf: got %b/%0d expected 0/0", status_unf, status_unf_count); end
    reset = 0;
    step();
    checks++; if (link_valid !== 1'b1) begin errors++; $display("FAIL valid_after_reset: got %b expected 1", link_valid); end
  endtask

  task automatic test_stream();
    ctrl_ext_sync_en = 0; link_ready = 1; enable = '1;
    ctrl_arm = 1; step(); ctrl_arm = 0;
    checks++; if (status_state !== 2'd1) begin errors++; $display("FAIL stream_prefill: got %0d expected 1", status_state); end
    for (int k = 1; k <= 8; k++) begin
      s_valid = 1; s_data = DW'(k); step();
    end
    s_valid = 0;
    checks++; if (status_level !== 5'd8 || status_state !== 2'd1) begin errors++; $display("FAIL stream_level8: got lvl %0d st %0d expected 8/1", status_level, status_state); end
    step();
    checks++; if (status_state !== 2'd3) begin errors++; $display("FAIL stream_run: got %0d expected 3", status_state); end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (link_data !== DW'(k)) begin errors++; $display("FAIL stream_data%0d: got %0h expected %0h", k, link_data, k); end
      checks++; if (status_unf !== 1'b0) begin errors++; $display("FAIL stream_no_unf%0d: got %b expected 0", k, status_unf); end
    end
  endtask

  task automatic test_underflow();
    repeat (3) step();
    checks++; if (link_data !== '0) begin errors++; $display("FAIL unf_data: got %0h expected 0", link_data); end
    checks++; if (status_unf !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b expected 1", status_unf); end
    checks++; if (status_unf_count !== 16'(CNT_EN ? 3 : 0)) begin errors++; $display("FAIL unf_count3: got %0d expected %0d", status_unf_count, CNT_EN ? 3 : 0); end
    status_clr = 1; step(); status_clr = 0;
    checks++; if (status_unf !== 1'b1) begin errors++; $display("FAIL unf_clr_race: got %b expected 1", status_unf); end
    checks++; if (status_unf_count !== 16'(CNT_EN ? 1 : 0)) begin errors++; $display("FAIL unf_count_race: got %0d expected %0d", status_unf_count, CNT_EN ? 1 : 0); end
    link_ready = 0; status_clr = 1; step(); status_clr = 0;
    checks++; if (status_unf !== 1'b0 || status_unf_count !== 16'd0) begin errors++; $display("FAIL unf_clear: got %b/%0d expected 0/0", status_unf, status_unf_count); end
  endtask

  task automatic test_ext_sync();
    logic [DW-1:0] exp[$];
    ctrl_stop = 1; step(); ctrl_stop = 0;
    checks++; if (status_state !== 2'd0 || status_level !== '0) begin errors++; $display("FAIL sync_stop: got st %0d lvl %0d expected 0/0", status_state, status_level); end
    ctrl_ext_sync_en = 1; ext_sync = 1; link_ready = 0; enable = '1;
    ctrl_arm = 1; step(); ctrl_arm = 0;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1; s_data = rand_beat(); exp.push_back(s_data); step();
    end
    s_valid = 0;
    for (int i = 0; i < 4 && status_state != 2'd2; i++) step();
    checks++; if (status_state !== 2'd2) begin errors++; $display("FAIL sync_wait: got %0d expected 2", status_state); end
    repeat (4) step();
    checks++; if (status_state !== 2'd2) begin errors++; $display("FAIL sync_held_high: got %0d expected 2", status_state); end
    ext_sync = 0; step();
    checks++; if (status_state !== 2'd2) begin errors++; $display("FAIL sync_low: got %0d expected 2", status_state); end
    ext_sync = 1; step();
    checks++; if (status_state !== 2'd3) begin errors++; $display("FAIL sync_edge_run: got %0d expected 3", status_state); end
    ext_sync = 0;
    repeat (2) step();
    checks++; if (status_level !== 5'd8 || link_data !== '0 || status_unf !== 1'b0) begin errors++; $display("FAIL sync_hold: got lvl %0d data %0h unf %b expected 8/0/0", status_level, link_data, status_unf); end
    link_ready = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++; if (link_data !== exp[k]) begin errors++; $display("FAIL sync_data%0d: got %0h expected %0h", k, link_data, exp[k]); end
    end
    link_ready = 0;
  endtask

  task automatic test_mask();
    ctrl_stop = 1; step(); ctrl_stop = 0;
    ctrl_ext_sync_en = 0; enable = 4'b0101; link_ready = 0;
    ctrl_arm = 1; step(); ctrl_arm = 0;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1; s_data = '1; step();
    end
    s_valid = 0;
    for (int i = 0; i < 4 && status_state != 2'd3; i++) step();
    checks++; if (status_state !== 2'd3) begin errors++; $display("FAIL mask_run: got %0d expected 3", status_state); end
    link_ready = 1; step();
    checks++; if (link_data !== {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL mask_0101: got %0h", link_data); end
    enable = 4'b1010; step();
    checks++; if (link_data !== {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0}) begin errors++; $display("FAIL mask_1010: got %0h", link_data); end
    checks++; if (status_level !== 5'd6) begin errors++; $display("FAIL mask_level: got %0d expected 6", status_level); end
    link_ready = 0; enable = '1;
  endtask

  task automatic test_full();
    ctrl_stop = 1; step(); ctrl_stop = 0;
    ctrl_ext_sync_en = 1; ext_sync = 1; link_ready = 0;
    ctrl_arm = 1; step(); ctrl_arm = 0;
    s_valid = 1;
    for (int k = 0; k < 20; k++) begin s_data = rand_beat(); step(); end
    checks++; if (status_level !== 5'd16 || s_ready !== 1'b0) begin errors++; $display("FAIL full: got lvl %0d rdy %b expected 16/0", status_level, s_ready); end
    ctrl_stop = 1; ctrl_arm = 1; step(); clear_pulses();
    s_valid = 0; ext_sync = 0;
    checks++; if (status_state !== 2'd0 || status_level !== '0) begin errors++; $display("FAIL stop_over_arm: got st %0d lvl %0d expected 0/0", status_state, status_level); end
  endtask

  task automatic test_reset_mid_run();
    ctrl_ext_sync_en = 0; link_ready = 0;
    ctrl_arm = 1; step(); ctrl_arm = 0;
    for (int k = 0; k < 8; k++) begin s_valid = 1; s_data = rand_beat(); step(); end
    s_valid = 0;
    for (int i = 0; i < 4 && status_state != 2'd3; i++) step();
    link_ready = 1; repeat (3) step(); link_ready = 0;
    checks++; if (status_level !== 5'd5 || status_state !== 2'd3) begin errors++; $display("FAIL mid_run_level: got lvl %0d st %0d expected 5/3", status_level, status_state); end
    reset = 1; model_reset(); #2;
    checks++; if (status_state !== 2'd0 || link_data !== '0 || link_valid !== 1'b0 || status_level !== '0) begin errors++; $display("FAIL mid_run_reset: st %0d data %0h vld %b lvl %0d", status_state, link_data, link_valid, status_level); end
    @(posedge clk); #1; reset = 0;
    step();
    checks++; if (link_valid !== 1'b1) begin errors++; $display("FAIL mid_run_valid: got %b expected 1", link_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      ctrl_arm   = ($urandom % 12) == 0;
      ctrl_stop  = ($urandom % 60) == 0;
      status_clr = ($urandom % 30) == 0;
      if (($urandom % 50) == 0) ctrl_ext_sync_en = $urandom;
      if (($urandom % 40) == 0) enable = NCH'($urandom);
      ext_sync   = ($urandom % 3) == 0;
      link_ready = ($urandom % 2) == 0;
      s_valid    = ($urandom % 4) != 0;
      s_data     = rand_beat();
      step();
      checks++; if (status_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state@%0d: got %0d expected %0d", n, status_state, m_state); end
      checks++; if (status_level !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d expected %0d", n, status_level, m_q.size()); end
      checks++; if (link_data !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %0h expected %0h", n, link_data, m_data); end
      checks++; if (s_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, s_ready, exp_ready()); end
      checks++; if (status_unf !== m_unf) begin errors++; $display("FAIL rnd_unf@%0d: got %b expected %b", n, status_unf, m_unf); end
      checks++; if (status_unf_count !== 16'(exp_cnt())) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d expected %0d", n, status_unf_count, exp_cnt()); end
      checks++; if (link_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, link_valid, m_valid); end
    end
    clear_pulses();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_ext_sync();
    test_mask();
    test_full();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
